// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared note-entry types and constants for the recorder and auto-play reader
package piano_pkg;

   // Note code meaning "no note sounding"
   localparam logic [3:0] NOTE_REST = 4'hF;

   // Buffer entry width and largest duration a single entry can hold
   localparam int ENTRY_W = 12;
   localparam int DUR_MAX = 255;

   // Recorder control states
   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      REC,
      FLUSH,
      FULL
   } rec_state_t;

   // One buffer entry: note code in the upper nibble, duration ticks below
   typedef struct packed {
      logic [3:0] note;
      logic [7:0] dur;
   } note_entry_t;

   // A closed segment always records at least one tick so it stays audible
   function automatic logic [7:0] dur_floor1(input logic [7:0] d);
      return (d == 8'd0) ? 8'd1 : d;
   endfunction

endpackage

// File: rtl/note_ram.sv
// rtl/note_ram.sv - DEPTH x 12 note buffer, one write port, registered read port
module note_ram
   import piano_pkg::*;
#(
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  note_entry_t   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output note_entry_t   o_rdata
);

   // Storage array; contents survive reset so a song outlives a reset pulse
   note_entry_t r_mem [DEPTH];
   note_entry_t r_rdata;

   // Write port
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read register: only this output register is reset, never the array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - records debounced, remapped key play as {note,dur} entries; SONG_RECORDER_REST_EN also records rests
module song_recorder
   import piano_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int TICK_CYCLES = 5_000_000,
   parameter int DEB_CYCLES  = 1_000_000,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               clear,
   input  logic [7:0]         key_board_in,
   input  logic [31:0]        key_map,
   input  logic [AW-1:0]      rd_addr,
   output logic [ENTRY_W-1:0] rd_data,
   output logic [AW:0]        length,
   output logic               full,
   output logic               busy
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [DW-1:0] C_DEB       = DW'(DEB_CYCLES);
   localparam logic [AW:0]   C_LEN_MAX   = (AW + 1)'(DEPTH);

   rec_state_t      r_state;
   rec_state_t      w_state_nxt;

   logic [3:0]      w_raw;
   logic [3:0]      r_cand;
   logic [DW-1:0]   r_deb_cnt;
   logic [DW-1:0]   w_deb_nxt;
   logic            w_deb_ok;
   logic [3:0]      r_stable;

   logic [3:0]      r_code;
   logic [TW-1:0]   r_tick;
   logic [7:0]      r_dur;
   logic [TW-1:0]   w_tick_base;
   logic [7:0]      w_dur_base;
   logic            w_tick_wrap;
   logic            w_sat;

   logic            w_close;
   logic            w_sat_close;
   logic            w_seg_start;
   logic            w_seg_run;
   logic            w_keep;
   logic            w_we;
   note_entry_t     w_wdata;
   note_entry_t     w_rdata;
   logic [AW:0]     r_length;

   // Raw code: lowest-index pressed key picks its nibble from the remap table
   always_comb begin
      w_raw = NOTE_REST;
      for (int i = 7; i >= 0; i--) begin
         if (key_board_in[i]) begin
            w_raw = key_map[31-4*i -: 4];
         end
      end
   end

   // The current raw code counts as held for its first cycle, so DEB_CYCLES
   // cycles of the same code are needed before it becomes stable
   assign w_deb_nxt = (w_raw != r_cand)      ? DW'(1) :
                      (r_deb_cnt == C_DEB)   ? C_DEB  :
                                               r_deb_cnt + 1'b1;
   assign w_deb_ok  = (w_deb_nxt >= C_DEB);

   // Debounce filter: candidate code, hold counter and stable code
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cand    <= NOTE_REST;
         r_deb_cnt <= C_DEB;
         r_stable  <= NOTE_REST;
      end else begin
         r_cand    <= w_raw;
         r_deb_cnt <= w_deb_nxt;
         if (w_deb_ok) begin
            r_stable <= w_raw;
         end
      end
   end

   // Segment timing: a starting segment counts its first cycle from zero
   assign w_tick_base = w_seg_start ? '0 : r_tick;
   assign w_dur_base  = w_seg_start ? '0 : r_dur;
   assign w_tick_wrap = (w_tick_base == C_TICK_LAST);

   // Only meaningful for a running segment: this cycle completes tick 255
   assign w_sat = (r_tick == C_TICK_LAST) && (r_dur == 8'(DUR_MAX - 1));

`ifdef SONG_RECORDER_REST_EN
   assign w_keep = 1'b1;
`else
   assign w_keep = (r_code != NOTE_REST);
`endif

   // Closed segments are kept only when the buffer still has room
   assign w_we = w_close && w_keep && (r_length != C_LEN_MAX);

   assign w_wdata.note = r_code;
   assign w_wdata.dur  = w_sat_close ? 8'(DUR_MAX) : dur_floor1(r_dur);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and segment control; clear overrides every other decision
   always_comb begin
      w_state_nxt = r_state;
      w_close     = 1'b0;
      w_sat_close = 1'b0;
      w_seg_start = 1'b0;
      w_seg_run   = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (!enable) begin
               w_state_nxt = IDLE;
            end else if (r_stable != NOTE_REST) begin
               w_state_nxt = REC;
               w_seg_start = 1'b1;
               w_seg_run   = 1'b1;
            end
         end
         REC: begin
            if (!enable) begin
               w_state_nxt = FLUSH;
            end else if (r_length == C_LEN_MAX) begin
               w_state_nxt = FULL;
            end else begin
               w_seg_run = 1'b1;
               if (r_stable != r_code) begin
                  w_close     = 1'b1;
                  w_seg_start = 1'b1;
               end else if (w_sat) begin
                  w_close     = 1'b1;
                  w_sat_close = 1'b1;
               end
            end
         end
         FLUSH: begin
            w_close     = 1'b1;
            w_state_nxt = IDLE;
         end
         FULL: begin
            if (!enable) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      if (clear) begin
         w_state_nxt = IDLE;
         w_close     = 1'b0;
         w_sat_close = 1'b0;
         w_seg_start = 1'b0;
         w_seg_run   = 1'b0;
      end
   end

   // Open segment: its code, the cycle-within-tick counter and the tick count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_code <= NOTE_REST;
         r_tick <= '0;
         r_dur  <= '0;
      end else begin
         if (w_seg_start) begin
            r_code <= r_stable;
         end
         if (w_sat_close) begin
            r_tick <= '0;
            r_dur  <= '0;
         end else if (w_seg_run) begin
            r_tick <= w_tick_wrap ? '0 : w_tick_base + 1'b1;
            r_dur  <= w_dur_base + {7'd0, w_tick_wrap};
         end
      end
   end

   // Entry count: saturates at DEPTH, emptied by clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_length <= '0;
      end else if (clear) begin
         r_length <= '0;
      end else if (w_we) begin
         r_length <= r_length + 1'b1;
      end
   end

   note_ram #(
      .DEPTH (DEPTH)
   ) u_note_ram (
      .clk     (clk),
      .rst_n   (rst),
      .i_we    (w_we),
      .i_waddr (r_length[AW-1:0]),
      .i_wdata (w_wdata),
      .i_raddr (rd_addr),
      .o_rdata (w_rdata)
   );

   assign rd_data = w_rdata;
   assign length  = r_length;
   assign full    = (r_length == C_LEN_MAX);
   assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - scoreboard bench for song_recorder, directed cases plus random songs
module tb_song_recorder;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int TICK  = 4;
   localparam int DEB   = 2;
   localparam logic [31:0] ID_MAP = 32'h0123_4567;
`ifdef SONG_RECORDER_REST_EN
   localparam bit REST_EN = 1'b1;
`else
   localparam bit REST_EN = 1'b0;
`endif

   typedef struct { logic [7:0] keys; int n; } step_t;
   typedef struct { logic [3:0] code; int n; } seg_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [7:0]    key_board_in = 8'h00;
   logic [31:0]   key_map = ID_MAP;
   logic [AW-1:0] rd_addr = '0;
   logic [11:0]   rd_data;
   logic [AW:0]   length;
   logic          full;
   logic          busy;

   int            errors = 0;
   int            checks = 0;
   logic [11:0]   exp_q[$];
   int            exp_len = 0;
   int            model_cnt = 0;
   step_t         song[$];
   logic [AW-1:0] peek_addr = '0;
   int            peek_seq = 0;

   song_recorder #(
      .DEPTH       (DEPTH),
      .TICK_CYCLES (TICK),
      .DEB_CYCLES  (DEB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .clear        (clear),
      .key_board_in (key_board_in),
      .key_map      (key_map),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .length       (length),
      .full         (full),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] code_of(input logic [7:0] k, input logic [31:0] m);
      for (int i = 0; i < 8; i++) begin
         if (k[i]) return m[31-4*i -: 4];
      end
      return 4'hF;
   endfunction

   task automatic emit(input logic [3:0] code, input int dur);
      if (code != 4'hF || REST_EN) begin
         if (model_cnt < DEPTH) exp_q.push_back({code, 8'(dur)});
         model_cnt++;
      end
   endtask

   // Reference: per-code segment lengths from the step list, then entries
   task automatic build_expect(input logic [31:0] map);
      seg_t       segs[$];
      logic [3:0] c;
      int         n;
      int         t;
      model_cnt = 0;
      segs.push_back('{4'hF, 0});
      for (int i = 0; i <= song.size(); i++) begin
         if (i < song.size()) begin
            c = code_of(song[i].keys, map);
            n = song[i].n;
         end else begin
            c = 4'hF;
            n = DEB + 4;
         end
         if (n < DEB || segs[segs.size()-1].code == c) segs[segs.size()-1].n += n;
         else segs.push_back('{c, n});
      end
      while (segs.size() > 0 && segs[0].code == 4'hF) void'(segs.pop_front());
      if (segs.size() > 0 && segs[segs.size()-1].code == 4'hF) void'(segs.pop_back());
      foreach (segs[j]) begin
         t = segs[j].n / TICK;
         while (t >= 255) begin
            emit(segs[j].code, 255);
            t -= 255;
         end
         emit(segs[j].code, (t == 0) ? 1 : t);
      end
      exp_len = (model_cnt < DEPTH) ? model_cnt : DEPTH;
   endtask

   task automatic start_song(input logic [31:0] map);
      key_map = map;
      key_board_in = 8'h00;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic run_song(input logic [31:0] map, input bit finish, input string name);
      start_song(map);
      foreach (song[i]) begin
         key_board_in = song[i].keys;
         repeat (song[i].n) @(negedge clk);
      end
      key_board_in = 8'h00;
      repeat (DEB + 4) @(negedge clk);
      if (finish) begin
         enable = 1'b0;
         repeat (3) @(negedge clk);
         check({name, " length"}, length, exp_len);
         check({name, " busy"}, busy, 0);
         check({name, " drained"}, exp_q.size(), 0);
      end
   endtask

   // Monitor: every new entry (or requested peek) is read back and compared
   initial begin
      int          prev_len;
      bit          pend;
      logic [11:0] pend_exp;
      int          seen;
      prev_len = 0;
      pend = 1'b0;
      pend_exp = '0;
      seen = 0;
      forever begin
         @(negedge clk);
         if (pend) begin
            check("entry", rd_data, pend_exp);
            pend = 1'b0;
         end
         if (int'(length) > prev_len || peek_seq != seen) begin
            if (peek_seq != seen) seen = peek_seq;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_entry: length %0d with no entry expected", length);
            end else begin
               pend_exp = exp_q.pop_front();
               rd_addr = (int'(length) > prev_len) ? AW'(length - 1'b1) : peek_addr;
               pend = 1'b1;
            end
         end
         prev_len = int'(length);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset length", length, 0);
      check("reset full", full, 0);
      check("reset busy", busy, 0);
      check("reset rd_data", rd_data, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // single note
      song.delete();
      song.push_back('{8'h04, 20});
      exp_q.push_back(12'h205);
      exp_len = 1;
      run_song(ID_MAP, 1, "single");

      // rests between notes
      song.delete();
      song.push_back('{8'h02, 8});
      song.push_back('{8'h00, 12});
      song.push_back('{8'h80, 8});
      exp_q.push_back(12'h102);
      if (REST_EN) exp_q.push_back(12'hF03);
      exp_q.push_back(12'h702);
      exp_len = REST_EN ? 3 : 2;
      run_song(ID_MAP, 1, "rests");

      // remap and lowest-key priority
      song.delete();
      song.push_back('{8'h81, 8});
      exp_q.push_back(12'h502);
      exp_len = 1;
      run_song(32'h5123_4567, 1, "remap");

      // duration saturation
      song.delete();
      song.push_back('{8'h01, 1100});
      exp_q.push_back(12'h0FF);
      exp_q.push_back(12'h014);
      exp_len = 2;
      run_song(ID_MAP, 1, "saturate");

      // glitch never recorded
      song.delete();
      song.push_back('{8'h08, 1});
      song.push_back('{8'h00, 10});
      exp_len = 0;
      run_song(ID_MAP, 1, "glitch");

      // fill the buffer, overflow, then clear while still enabled
      song.delete();
      for (int i = 0; i < 5; i++) begin
         song.push_back('{8'(1 << i), 4});
         if (i < 4) song.push_back('{8'h00, 4});
      end
      if (REST_EN) begin
         exp_q.push_back(12'h001);
         exp_q.push_back(12'hF01);
         exp_q.push_back(12'h101);
         exp_q.push_back(12'hF01);
      end else begin
         exp_q.push_back(12'h001);
         exp_q.push_back(12'h101);
         exp_q.push_back(12'h201);
         exp_q.push_back(12'h301);
      end
      run_song(ID_MAP, 0, "full");
      check("full flag", full, 1);
      check("full length", length, 4);
      check("full busy", busy, 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear length", length, 0);
      check("clear full", full, 0);
      @(negedge clk);
      check("rearm busy", busy, 1);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("full drained", exp_q.size(), 0);

      // reset in the middle of a recording
      exp_q.push_back(12'h403);
      start_song(ID_MAP);
      key_board_in = 8'h10;
      repeat (12) @(negedge clk);
      key_board_in = 8'h00;
      repeat (6) @(negedge clk);
      key_board_in = 8'h20;
      repeat (10) @(negedge clk);
      check("pre-reset length", length, 1);
      rst = 1'b0;
      @(negedge clk);
      check("midreset length", length, 0);
      check("midreset full", full, 0);
      check("midreset busy", busy, 0);
      enable = 1'b0;
      key_board_in = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      exp_q.push_back(12'h403);
      peek_addr = '0;
      peek_seq++;
      repeat (3) @(negedge clk);
      check("reset ram kept", exp_q.size(), 0);

      // random songs against the reference
      for (int s = 0; s < 8; s++) begin
         logic [31:0] map;
         int          nst;
         map = (s % 2 == 0) ? ID_MAP : 32'($urandom());
         song.delete();
         nst = $urandom_range(1, 4);
         for (int k = 0; k < nst; k++) begin
            song.push_back('{8'($urandom_range(1, 255)), $urandom_range(2, 30)});
            if ($urandom_range(0, 1) == 1) song.push_back('{8'h00, $urandom_range(2, 20)});
         end
         build_expect(map);
         run_song(map, 1, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
